// File: rtl/wb_pipe_buf_if.sv
// MEM->WB buffer bus: enqueue side, head/dequeue side, flush and forwarding lookup.
interface wb_pipe_buf_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_wd;
  logic              in_wreg;
  logic [DATA_W-1:0] in_wdata;
  logic [DATA_W-1:0] in_hi;
  logic [DATA_W-1:0] in_lo;
  logic              in_whilo;
  logic              in_llbit_we;
  logic              in_llbit_value;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_wd;
  logic              out_wreg;
  logic [DATA_W-1:0] out_wdata;
  logic [DATA_W-1:0] out_hi;
  logic [DATA_W-1:0] out_lo;
  logic              out_whilo;
  logic              out_llbit_we;
  logic              out_llbit_value;

  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] fwd_raddr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // Buffer side
  modport slave (
    input  flush, in_valid, in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo,
           in_llbit_we, in_llbit_value, out_ready, fwd_raddr,
    output in_ready, out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo,
           out_whilo, out_llbit_we, out_llbit_value, count, fwd_hit, fwd_data
  );

  // Pipeline / environment side
  modport master (
    output flush, in_valid, in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo,
           in_llbit_we, in_llbit_value, out_ready, fwd_raddr,
    input  in_ready, out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo,
           out_whilo, out_llbit_we, out_llbit_value, count, fwd_hit, fwd_data
  );
endinterface

// File: rtl/wb_pipe_buf.sv
// MEM/WB decoupling FIFO: in-order DEPTH-entry buffer with valid/ready, flush,
// bubble output on empty and youngest-first forwarding lookup for decode.
module wb_pipe_buf #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 2,
  parameter int HILO_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  wb_pipe_buf_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              whilo;
    logic              llbit_we;
    logic              llbit_value;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q;
  logic   [DEPTH-1:0] vld_q, vld_d;
  logic   [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic   [CNT_W-1:0] count_q, count_d;

  logic   in_ready, out_valid, push, pop;
  entry_t in_ent, head;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  // r0 writes are dropped at entry; HI/LO fields vanish when not configured
  always_comb begin
    in_ent             = '0;
    in_ent.wd          = bus.in_wd;
    in_ent.wreg        = bus.in_wreg & (bus.in_wd != '0);
    in_ent.wdata       = bus.in_wdata;
    in_ent.hi          = (HILO_EN != 0) ? bus.in_hi    : '0;
    in_ent.lo          = (HILO_EN != 0) ? bus.in_lo    : '0;
    in_ent.whilo       = (HILO_EN != 0) ? bus.in_whilo : 1'b0;
    in_ent.llbit_we    = bus.in_llbit_we;
    in_ent.llbit_value = bus.in_llbit_value;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      vld_d    = '0;
    end else begin
      if (pop) begin
        rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        vld_d[rd_ptr_q] = 1'b0;
      end
      if (push) begin
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        vld_d[wr_ptr_q] = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      if (push && !bus.flush) mem_q[wr_ptr_q] <= in_ent;
    end
  end

  // Head is gated to an all-zero bubble while empty
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid;
  assign bus.out_wd          = head.wd;
  assign bus.out_wreg        = head.wreg;
  assign bus.out_wdata       = head.wdata;
  assign bus.out_hi          = head.hi;
  assign bus.out_lo          = head.lo;
  assign bus.out_whilo       = head.whilo;
  assign bus.out_llbit_we    = head.llbit_we;
  assign bus.out_llbit_value = head.llbit_value;
  assign bus.count           = count_q;

  // Walk oldest to youngest so the last match (youngest) wins
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  fwd_idx;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PTR_W'(i);
      if (vld_q[fwd_idx] && mem_q[fwd_idx].wreg && (bus.fwd_raddr != '0) &&
          (mem_q[fwd_idx].wd == bus.fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_q[fwd_idx].wdata;
      end
    end
  end

  assign bus.fwd_hit  = fwd_hit;
  assign bus.fwd_data = fwd_data;
endmodule
